// File: rtl/msf_input_conditioner.sv
// msf_input_conditioner
// Conditions the raw MSF demodulator level for the bit sampler:
//   - two-flop synchroniser for the asynchronous data_i pin
//   - saturating up/down integrator with hysteresis on its end stops
//   - registered rise/fall strobes aligned with the filtered level
//   - loss-of-signal flag after LOS_MS milliseconds without an edge
// Optional build macro MSF_COND_PULSE_WIDTH_EN adds width_o/width_valid_o,
// which report how many cycles data_o stayed high, presented at fall_o.
// Reset is synchronous and active-high; reset discards all history.

module msf_input_conditioner #(
  parameter int unsigned CLK_FREQ  = 12500,  // system clock in Hz
  parameter int unsigned INTEG_MAX = 15,     // integrator ceiling, min 1
  parameter int unsigned LOS_MS    = 3000    // no-edge time before LOS
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_i,
  output logic        data_o,
  output logic        rise_o,
  output logic        fall_o,
  output logic        los_o
`ifdef MSF_COND_PULSE_WIDTH_EN
  ,
  output logic [15:0] width_o,
  output logic        width_valid_o
`endif
);

  // Elaboration-time constants.
  localparam int unsigned LOS_CYCLES = (CLK_FREQ * LOS_MS) / 1000;
  localparam int unsigned CNT_W      = $clog2(INTEG_MAX + 1);
  localparam int unsigned LOS_W      = $clog2(LOS_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(INTEG_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [LOS_W-1:0] LOS_MAX = LOS_W'(LOS_CYCLES);
  localparam logic [LOS_W-1:0] LOS_ONE = LOS_W'(1);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic             sync1_q;
  logic             s_q;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             data_q,    data_d;
  logic             rise_q,    rise_d;
  logic             fall_q,    fall_d;
  logic [LOS_W-1:0] los_cnt_q, los_cnt_d;

  // Synchroniser: the only flops that ever see data_i.
  always_ff @(posedge clk_i) begin
    // NOTE: registers are written with non-blocking assignments so every
    // flop samples the pre-edge values; blocking here would collapse the
    // two synchroniser stages into one.
    if (rst_i) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      sync1_q <= data_i;
      s_q     <= sync1_q;
    end
  end

  // Integrator: count toward the synchronised level, saturating at both ends.
  always_comb begin
    // NOTE: the default assignment first guarantees every path drives cnt_d,
    // so no latch is inferred when neither branch below is taken.
    cnt_d = cnt_q;
    if (s_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (!s_q && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Hysteresis: the output only moves when the integrator sits on an end stop.
  always_comb begin
    data_d = data_q;
    if (cnt_q == CNT_MAX) begin
      data_d = 1'b1;
    end else if (cnt_q == '0) begin
      data_d = 1'b0;
    end
    rise_d = data_d & ~data_q;
    fall_d = ~data_d & data_q;
  end

  // Loss-of-signal timer: restarts with each strobe, saturates at LOS_CYCLES.
  always_comb begin
    los_cnt_d = los_cnt_q;
    if (rise_d || fall_d) begin
      los_cnt_d = '0;
    end else if (los_cnt_q != LOS_MAX) begin
      los_cnt_d = los_cnt_q + LOS_ONE;
    end
  end

  // Filter, strobe and LOS registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      data_q    <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      los_cnt_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      los_cnt_q <= los_cnt_d;
    end
  end

  assign data_o = data_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign los_o  = (los_cnt_q == LOS_MAX);

`ifdef MSF_COND_PULSE_WIDTH_EN
  // ---------------------------------------------------------------------
  // Pulse width measurement
  // ---------------------------------------------------------------------
  logic [15:0] wcnt_q,   wcnt_d;
  logic [15:0] width_q,  width_d;
  logic        wvalid_q, wvalid_d;

  // Run-length counter of data_o high; result latched at the falling edge.
  always_comb begin
    wcnt_d   = wcnt_q;
    width_d  = width_q;
    wvalid_d = fall_d;
    if (rise_d) begin
      wcnt_d = 16'd1;
    end else if (data_q && (wcnt_q != 16'hFFFF)) begin
      wcnt_d = wcnt_q + 16'd1;
    end
    // wcnt_q already holds the number of cycles data_o was high.
    if (fall_d) begin
      width_d = wcnt_q;
    end
  end

  // Width registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wcnt_q   <= '0;
      width_q  <= '0;
      wvalid_q <= 1'b0;
    end else begin
      wcnt_q   <= wcnt_d;
      width_q  <= width_d;
      wvalid_q <= wvalid_d;
    end
  end

  assign width_o       = width_q;
  assign width_valid_o = wvalid_q;
`endif

endmodule
